ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/ram_responder.sv | 131 +++++++++++++
 tb/tb_ram_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types.
//   ramstate_t : status reported by the RAM responder to the memory controller.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the controller's RAM request bus.
// Holds DEPTH 32-bit words indexed by ramaddr[31:2]. A request held stable
// is answered after LAT BUSY cycles with a single ACCESS cycle.
//
// Parameters
//   LAT      : BUSY cycles before ACCESS (1..15)
//   DEPTH    : number of 32-bit words
// Ports
//   CLK      : clock, rising edge
//   RST      : asynchronous active-high reset (also clears the memory)
//   ramREN   : read request
//   ramWEN   : write request
//   ramaddr  : byte address
//   ramstore : write data
//   ramload  : read data, valid only in ACCESS of a read, otherwise 0
//   ramstate : current responder state
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output ramstate_t   ramstate
);

  localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT4 = 4'(LAT);

  ramstate_t     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;
  logic [31:0]   mem_q [DEPTH];

  logic          req_any;
  logic          req_valid;
  logic          req_err;
  logic          in_range;
  logic [IW-1:0] req_idx;
  logic          req_changed;
  logic          mem_we;

  assign in_range  = {2'b00, ramaddr[31:2]} < 32'(DEPTH);
  assign req_any   = ramREN | ramWEN;
  assign req_valid = (ramREN ^ ramWEN) && (ramaddr[1:0] == 2'b00) && in_range;
  assign req_err   = req_any && !req_valid;
  // Only meaningful once req_valid holds, which guarantees the index fits IW bits.
  assign req_idx     = ramaddr[IW+1:2];
  assign req_changed = (req_idx != idx_q) || (ramWEN != wr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    unique case (state_q)
      FREE: begin
        if (req_err) begin
          state_d = ERROR;
        end else if (req_valid) begin
          state_d = BUSY;
          cnt_d   = 4'd1;
          idx_d   = req_idx;
          wr_d    = ramWEN;
        end
      end
      BUSY: begin
        if (!req_any) begin
          state_d = FREE;
        end else if (req_err) begin
          state_d = ERROR;
        end else if (req_changed) begin
          // Request moved under us: restart the latency window.
          cnt_d = 4'd1;
          idx_d = req_idx;
          wr_d  = ramWEN;
        end else if (cnt_q == LAT4) begin
          state_d = ACCESS;
        end else if (cnt_q != 4'hF) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACCESS: begin
        state_d = FREE;
      end
      ERROR: begin
        if (!req_any) state_d = FREE;
      end
      default: begin
        state_d = FREE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FREE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
    end
  end

  // The write commits on the edge leaving ACCESS, and only if the master
  // is still asserting ramWEN at that edge.
  assign mem_we = (state_q == ACCESS) && wr_q && ramWEN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i[IW-1:0]] <= '0;
    end else if (mem_we) begin
      mem_q[idx_q] <= ramstore;
    end
  end

  assign ramload  = ((state_q == ACCESS) && !wr_q) ? mem_q[idx_q] : '0;
  assign ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder (LAT=2, DEPTH=256).
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 256;
  localparam int          LATI  = LAT;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        ren   = 1'b0;
  logic        wen   = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] store = '0;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  ram_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK      (clk),
    .RST      (rst),
    .ramREN   (ren),
    .ramWEN   (wen),
    .ramaddr  (addr),
    .ramstore (store),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_phase: 0 idle, 1..LAT = n-th waiting cycle of the current request,
  // LAT+1 = serving cycle, -1 = rejected request still held.
  int          m_phase = 0;
  int unsigned m_idx   = 0;
  bit          m_wr    = 1'b0;
  logic [31:0] m_mem [DEPTH];

  logic        m_any, m_ok;
  int unsigned m_widx;
  assign m_widx = addr >> 2;
  assign m_any  = ren | wen;
  assign m_ok   = (ren ^ wen) && (addr[1:0] == 2'b00) && (m_widx < DEPTH);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_idx   <= 0;
      m_wr    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else if (m_phase == -1) begin
      if (!m_any) m_phase <= 0;
    end else if (m_phase == LATI + 1) begin
      if (m_wr && wen) m_mem[m_idx] <= store;
      m_phase <= 0;
    end else if (m_phase == 0) begin
      if (m_any && !m_ok) m_phase <= -1;
      else if (m_ok) begin
        m_phase <= 1;
        m_idx   <= m_widx;
        m_wr    <= wen;
      end
    end else begin
      if (!m_any) m_phase <= 0;
      else if (!m_ok) m_phase <= -1;
      else if (m_widx != m_idx || wen != m_wr) begin
        m_phase <= 1;
        m_idx   <= m_widx;
        m_wr    <= wen;
      end else m_phase <= m_phase + 1;
    end
  end

  ramstate_t   m_state;
  logic [31:0] m_load;
  always_comb begin
    m_state = FREE;
    m_load  = '0;
    if (m_phase == -1) m_state = ERROR;
    else if (m_phase == LATI + 1) begin
      m_state = ACCESS;
      if (!m_wr) m_load = m_mem[m_idx];
    end else if (m_phase > 0) m_state = BUSY;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_state", 32'(ramstate), 32'(m_state));
      chk("model_load", ramload, m_load);
    end
  end

  task automatic lit(input string name, input ramstate_t s, input logic [31:0] ld);
    chk({name, "_state"}, 32'(ramstate), 32'(s));
    chk({name, "_load"}, ramload, ld);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    ren   = r;
    wen   = w;
    addr  = a;
    store = d;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
    tick(LATI + 1);
    lit("wr_access", ACCESS, 32'h0);
    tick(1);
    drive(1'b0, 1'b0, '0, '0);
    lit("wr_done", FREE, 32'h0);
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, '0);
    tick(LATI);
    lit({name, "_busy"}, BUSY, 32'h0);
    tick(1);
    lit({name, "_access"}, ACCESS, exp);
    tick(1);
    drive(1'b0, 1'b0, '0, '0);
    lit({name, "_free"}, FREE, 32'h0);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 lit("rst_async", FREE, 32'h0);
    drive(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick(1);
  endtask

  bit          e_r [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit          e_w [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] e_a [4] = '{32'h40, 32'h41, 32'h400, 32'h42};

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #2 lit("reset", FREE, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(3);
    lit("idle", FREE, 32'h0);

    // write then read back 0x40
    drive(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    tick(1); lit("w40_busy1", BUSY, 32'h0);
    tick(1); lit("w40_busy2", BUSY, 32'h0);
    tick(1); lit("w40_access", ACCESS, 32'h0);
    tick(1); lit("w40_free", FREE, 32'h0);
    drive(1'b1, 1'b0, 32'h40, '0);
    tick(LATI); lit("r40_busy", BUSY, 32'h0);
    tick(1); lit("r40_access", ACCESS, 32'hDEADBEEF);
    tick(1); lit("r40_after", FREE, 32'h0);
    tick(1); lit("r40_reservice", BUSY, 32'h0);
    drive(1'b0, 1'b0, '0, '0);
    tick(1); lit("r40_abandon", FREE, 32'h0);

    // address change in first BUSY cycle restarts latency
    do_write(32'h80, 32'h11111111);
    do_write(32'h84, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 32'h80, '0);
    tick(1); lit("rs_busy1", BUSY, 32'h0);
    addr = 32'h84;
    tick(1); lit("rs_busy2", BUSY, 32'h0);
    tick(1); lit("rs_busy3", BUSY, 32'h0);
    tick(1); lit("rs_access", ACCESS, 32'hCAFEF00D);
    tick(1);
    drive(1'b0, 1'b0, '0, '0);
    lit("rs_free", FREE, 32'h0);
    do_read("r80", 32'h80, 32'h11111111);

    // error requests
    for (int k = 0; k < 4; k++) begin
      drive(e_r[k], e_w[k], e_a[k], 32'h55555555);
      tick(1); lit("err_enter", ERROR, 32'h0);
      tick(1); lit("err_hold", ERROR, 32'h0);
      drive(1'b0, 1'b0, '0, '0);
      tick(1); lit("err_exit", FREE, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h40, '0);
    tick(1); lit("busy_err_pre", BUSY, 32'h0);
    wen = 1'b1;
    tick(1); lit("busy_err", ERROR, 32'h0);
    drive(1'b0, 1'b0, '0, '0);
    tick(1); lit("busy_err_exit", FREE, 32'h0);
    do_read("r40_post_err", 32'h40, 32'hDEADBEEF);

    // write abandoned during ACCESS
    do_write(32'h20, 32'hA5A5A5A5);
    drive(1'b0, 1'b1, 32'h20, 32'h0BADF00D);
    tick(LATI + 1); lit("wdrop_access", ACCESS, 32'h0);
    wen = 1'b0;
    tick(1); lit("wdrop_free", FREE, 32'h0);
    do_read("r20", 32'h20, 32'hA5A5A5A5);

    // reset during ACCESS of a read
    do_write(32'h30, 32'h00000077);
    drive(1'b1, 1'b0, 32'h30, '0);
    tick(LATI + 1); lit("r30_access", ACCESS, 32'h00000077);
    pulse_reset();
    do_read("r30_post_rst", 32'h30, 32'h0);

    // reset during second BUSY cycle of a write
    drive(1'b0, 1'b1, 32'h10, 32'h12345678);
    tick(1); lit("w10_busy1", BUSY, 32'h0);
    tick(1); lit("w10_busy2", BUSY, 32'h0);
    pulse_reset();
    do_read("r10", 32'h10, 32'h0);
    do_read("r84_cleared", 32'h84, 32'h0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1);
  end

endmodule
